// File: rtl/onehot_rr_arbiter_pkg.sv
// rtl/onehot_rr_arbiter_pkg.sv - shared helpers for one-hot mux/arbiter blocks
package onehot_rr_arbiter_pkg;

    // Binary index width for an N-wide one-hot vector; never narrower than 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_rr_arbiter_if.sv
// rtl/onehot_rr_arbiter_if.sv - request/grant handshake bundle for the round-robin arbiter
interface onehot_rr_arbiter_if
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
);
    logic [N-1:0]     req;
    logic             flush;
    logic             out_ready;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             out_valid;

    modport master (
        output req, flush, out_ready,
        input  grant, grant_idx, out_valid
    );

    modport slave (
        input  req, flush, out_ready,
        output grant, grant_idx, out_valid
    );
endinterface

// File: rtl/onehot_prio_pick.sv
// rtl/onehot_prio_pick.sv - picks the first set req bit at or above a one-hot priority pointer, wrapping
module onehot_prio_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] prio,
    output logic [N-1:0] gnt
);
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] diff;
    logic [2*N-1:0] masked;

    // Subtracting the pointer from the doubled request clears the first set bit at/after it;
    // the AND isolates that bit and the fold maps the wrapped half back onto N bits.
    always_comb begin
        req_dbl = {req, req};
        diff    = req_dbl - {{N{1'b0}}, prio};
        masked  = req_dbl & ~diff;
        gnt     = masked[N-1:0] | masked[2*N-1:N];
    end
endmodule

// File: rtl/onehot_rr_arbiter.sv
// rtl/onehot_rr_arbiter.sv - round-robin arbiter driving a strictly one-hot (or zero) select
module onehot_rr_arbiter
    import onehot_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_width(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    onehot_rr_arbiter_if.slave   arb
);
    logic [N-1:0]     prio_q, prio_d;
    logic [N-1:0]     held_q, held_d;
    logic             lock_q, lock_d;
    logic [N-1:0]     pick;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             out_valid;
    logic             fire;

    onehot_prio_pick #(.N(N)) u_pick (
        .req  (arb.req),
        .prio (prio_q),
        .gnt  (pick)
    );

    // A locked grant is replayed untouched so the downstream select cannot move under back-pressure.
    always_comb begin
        grant = '0;
        if (!rst) begin
            grant = lock_q ? held_q : pick;
        end
        out_valid = |grant;
        fire      = out_valid & arb.out_ready;
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IDX_W'(i);
            end
        end
    end

    assign arb.grant     = grant;
    assign arb.grant_idx = grant_idx;
    assign arb.out_valid = out_valid;

    always_comb begin
        prio_d = prio_q;
        lock_d = lock_q;
        held_d = held_q;
        if (fire) begin
            prio_d = (grant << 1) | (grant >> (N - 1));
            lock_d = 1'b0;
        end else if (out_valid && !arb.flush) begin
            lock_d = 1'b1;
            held_d = grant;
        end
        if (arb.flush) begin
            lock_d = 1'b0;
            held_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= N'(1);
            lock_q <= 1'b0;
            held_q <= '0;
        end else begin
            prio_q <= prio_d;
            lock_q <= lock_d;
            held_q <= held_d;
        end
    end

    a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_prio_onehot:   assert property (@(posedge clk) disable iff (rst) $onehot(prio_q));
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb/tb_onehot_rr_arbiter.sv - directed and randomized self-checking bench for onehot_rr_arbiter
module tb_onehot_rr_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    onehot_rr_arbiter_if #(.N(N)) bus ();

    onehot_rr_arbiter #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    logic [N-1:0] m_prio, m_held, m_exp;
    logic         m_lock;
    int           waits [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] enc(input logic [N-1:0] g);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input logic [N-1:0] p);
        int s;
        logic [N-1:0] g;
        s = 0;
        g = '0;
        for (int i = 0; i < N; i++) if (p[i]) s = i;
        for (int k = 0; k < N; k++) begin
            if (g == '0 && r[(s + k) % N]) g[(s + k) % N] = 1'b1;
        end
        return g;
    endfunction

    // One directed cycle: drive inputs, check combinational outputs mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic [N-1:0] r, input logic rdy, input logic fl,
                       input logic [N-1:0] eg, input logic [1:0] ei);
        bus.req       = r;
        bus.out_ready = rdy;
        bus.flush     = fl;
        @(negedge clk);
        chk({tag, "_grant"}, 32'(bus.grant), 32'(eg));
        chk({tag, "_idx"},   32'(bus.grant_idx), 32'(ei));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(|eg));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", 4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0);
        rst = 1'b0;
        cyc("release", 4'b1111, 1'b0, 1'b0, 4'b0001, 2'd0);

        cyc("rot0", 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);
        cyc("rot1", 4'b1111, 1'b1, 1'b0, 4'b0010, 2'd1);
        cyc("rot2", 4'b1111, 1'b1, 1'b0, 4'b0100, 2'd2);
        cyc("rot3", 4'b1111, 1'b1, 1'b0, 4'b1000, 2'd3);
        cyc("rot4", 4'b1111, 1'b1, 1'b0, 4'b0001, 2'd0);

        cyc("bp0", 4'b0110, 1'b0, 1'b0, 4'b0010, 2'd1);
        cyc("bp1", 4'b0100, 1'b0, 1'b0, 4'b0010, 2'd1);
        cyc("bp2", 4'b0100, 1'b0, 1'b0, 4'b0010, 2'd1);
        cyc("bp_fire", 4'b0100, 1'b1, 1'b0, 4'b0010, 2'd1);
        cyc("bp_next", 4'b0100, 1'b1, 1'b0, 4'b0100, 2'd2);

        cyc("wrap0", 4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);
        cyc("wrap1", 4'b0011, 1'b1, 1'b0, 4'b0010, 2'd1);
        cyc("wrap2", 4'b0011, 1'b1, 1'b0, 4'b0001, 2'd0);

        cyc("fl_lock", 4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2);
        cyc("fl_held", 4'b0001, 1'b0, 1'b1, 4'b0100, 2'd2);
        cyc("fl_after", 4'b0001, 1'b0, 1'b1, 4'b0001, 2'd0);
        cyc("fl_prio", 4'b1011, 1'b0, 1'b0, 4'b0010, 2'd1);
        cyc("fl_fire", 4'b1011, 1'b1, 1'b1, 4'b0010, 2'd1);
        cyc("fl_adv", 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2);
        cyc("idle", 4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0);
        cyc("idle_keep", 4'b1111, 1'b0, 1'b1, 4'b0100, 2'd2);

        rst = 1'b1;
        cyc("rand_rst", 4'b1010, 1'b1, 1'b0, 4'b0000, 2'd0);
        rst    = 1'b0;
        m_prio = 4'b0001;
        m_lock = 1'b0;
        m_held = '0;
        for (int i = 0; i < N; i++) waits[i] = 0;

        for (int c = 0; c < 4000; c++) begin
            bus.req       = 4'($urandom_range(0, 15));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.flush     = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            m_exp = m_lock ? m_held : model_pick(bus.req, m_prio);
            chk("rand_grant", 32'(bus.grant), 32'(m_exp));
            chk("rand_onehot0", 32'($onehot0(bus.grant)), 32'd1);
            chk("rand_idx", 32'(bus.grant_idx), 32'(enc(m_exp)));
            if (|m_exp && bus.out_ready) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.req[i] && !m_exp[i]) begin
                        waits[i]++;
                        chk("starve", 32'(waits[i] <= N), 32'd1);
                    end else begin
                        waits[i] = 0;
                    end
                end
                m_prio = {m_exp[N-2:0], m_exp[N-1]};
                m_lock = 1'b0;
            end else begin
                for (int i = 0; i < N; i++) if (!bus.req[i]) waits[i] = 0;
                if (|m_exp && !bus.flush) begin
                    m_lock = 1'b1;
                    m_held = m_exp;
                end
            end
            if (bus.flush) begin
                m_lock = 1'b0;
                m_held = '0;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
